// File: rtl/v_hier_nibble_tx.sv
// Purpose: word-to-nibble serializer feeding the leaf avec bus and reassembling returned qvec nibbles.
// Latency: word accepted at E0, nibble k on avec in cycle k+1, out_valid in cycle NIBS+1 (NIBS+2 with parity).
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready; avec burst cannot be stalled.
// Optional feature: define V_HIER_PARITY_EN to append an XOR parity nibble and latch its return in out_par.
module v_hier_nibble_tx #(
    parameter int NIBS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*NIBS-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [3:0]          avec,
    output logic                avec_valid,
    output logic                avec_last,
    input  logic [3:0]          qvec,
    output logic [4*NIBS-1:0]   out_data,
    output logic [3:0]          out_par,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int W  = 4 * NIBS;
    localparam int CW = $clog2(NIBS + 1);
`ifdef V_HIER_PARITY_EN
    localparam int LAST = NIBS;
`else
    localparam int LAST = NIBS - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shreg;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_coll;
    logic            r_in_ready;
    logic            r_avec_vld;
    logic            r_avec_last;
    logic            r_out_vld;
    logic [CW-1:0]   w_cnt_inc;

    assign w_cnt_inc = r_cnt + CW'(1);

`ifdef V_HIER_PARITY_EN
    logic [3:0]      r_par;
    logic [3:0]      r_out_par;
    logic [3:0]      w_par_nxt;

    // Running XOR of the data nibbles already sent, including the one on avec now
    assign w_par_nxt = r_par ^ r_shreg[3:0];

    // Parity accumulator and the latched parity-return nibble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par     <= 4'h0;
            r_out_par <= 4'h0;
        end else if (r_state == ST_IDLE) begin
            if (in_valid) begin
                r_par     <= 4'h0;
                r_out_par <= 4'h0;
            end
        end else if (r_state == ST_SHIFT) begin
            r_par <= w_par_nxt;
            if (r_cnt == CW'(NIBS)) begin
                r_out_par <= qvec;
            end
        end
    end

    assign out_par = r_out_par;
`else
    assign out_par = 4'h0;
`endif

    // Control FSM with registered handshake/strobe outputs, shift register and collect register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_coll      <= '0;
            r_in_ready  <= 1'b1;
            r_avec_vld  <= 1'b0;
            r_avec_last <= 1'b0;
            r_out_vld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shreg     <= in_data;
                        r_cnt       <= '0;
                        r_coll      <= '0;
                        r_in_ready  <= 1'b0;
                        r_avec_vld  <= 1'b1;
                        r_avec_last <= (LAST_CNT == '0);
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    for (int i = 0; i < NIBS; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_coll[4*i +: 4] <= qvec;
                        end
                    end
`ifdef V_HIER_PARITY_EN
                    // After the last data nibble the parity nibble takes its place on avec
                    if (r_cnt == CW'(NIBS - 1)) begin
                        r_shreg <= W'(w_par_nxt);
                    end else begin
                        r_shreg <= r_shreg >> 4;
                    end
`else
                    r_shreg <= r_shreg >> 4;
`endif
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == LAST_CNT) begin
                        r_avec_vld  <= 1'b0;
                        r_avec_last <= 1'b0;
                        r_out_vld   <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_avec_last <= (w_cnt_inc == LAST_CNT);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_vld  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The shift register drains to zero by the end of a burst, so avec idles at 0
    assign avec       = r_shreg[3:0];
    assign avec_valid = r_avec_vld;
    assign avec_last  = r_avec_last;
    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_vld;
    assign out_data   = r_coll;

endmodule

// File: tb/tb_v_hier_nibble_tx.sv
// Directed bench for v_hier_nibble_tx: NIBS=4 instance plus a NIBS=2 instance.
// Downstream leaf model returns qvec = ~avec combinationally.
// Expected values hand-computed; parity-specific checks follow V_HIER_PARITY_EN.
module tb_v_hier_nibble_tx;

`ifdef V_HIER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  avec;
    logic        avec_valid;
    logic        avec_last;
    logic [3:0]  qvec;
    logic [15:0] out_data;
    logic [3:0]  out_par;
    logic        out_valid;
    logic        out_ready;

    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [3:0]  b_avec;
    logic        b_avec_valid;
    logic        b_avec_last;
    logic [3:0]  b_qvec;
    logic [7:0]  b_out_data;
    logic [3:0]  b_out_par;
    logic        b_out_valid;
    logic        b_out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign qvec   = ~avec;
    assign b_qvec = ~b_avec;

    v_hier_nibble_tx #(.NIBS(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .avec(avec), .avec_valid(avec_valid), .avec_last(avec_last),
        .qvec(qvec),
        .out_data(out_data), .out_par(out_par), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    v_hier_nibble_tx #(.NIBS(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .avec(b_avec), .avec_valid(b_avec_valid), .avec_last(b_avec_last),
        .qvec(b_qvec),
        .out_data(b_out_data), .out_par(b_out_par), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int seen;
        in_data     = 16'h0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_in_data   = 8'h0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_avec",       avec,       0);
        chk("rst_avec_valid", avec_valid, 0);
        chk("rst_avec_last",  avec_last,  0);
        chk("rst_out_data",   out_data,   0);
        chk("rst_out_par",    out_par,    0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_b_in_ready", b_in_ready, 1);
        reset = 1'b0;
        tick();

        // Single word 1A2C, out_ready high
        in_data   = 16'h1A2C;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 16'h0;
        chk("t1_avec0",  avec,       4'hC);
        chk("t1_vld0",   avec_valid, 1);
        chk("t1_last0",  avec_last,  0);
        chk("t1_inrdy",  in_ready,   0);
        tick();
        chk("t1_avec1",  avec,       4'h2);
        chk("t1_vld1",   avec_valid, 1);
        tick();
        chk("t1_avec2",  avec,       4'hA);
        chk("t1_last2",  avec_last,  0);
        tick();
        chk("t1_avec3",  avec,       4'h1);
        chk("t1_last3",  avec_last,  32'(1 - PAR));
        tick();
`ifdef V_HIER_PARITY_EN
        chk("t1_avecp",  avec,       4'h5);
        chk("t1_lastp",  avec_last,  1);
        tick();
`endif
        chk("t1_ovld",   out_valid,  1);
        chk("t1_odata",  out_data,   16'hE5D3);
        chk("t1_avld_off", avec_valid, 0);
`ifdef V_HIER_PARITY_EN
        chk("t1_opar",   out_par,    4'hA);
`endif
        tick();
        chk("t1_ovld_fall", out_valid, 0);
        chk("t1_inrdy_rise", in_ready, 1);

        // Backpressure: result held for 10 cycles, new word ignored
        out_ready = 1'b0;
        in_data   = 16'h1234;
        in_valid  = 1'b1;
        tick();
        in_data = 16'hAAAA;
        repeat (4 + PAR) tick();
        for (int i = 0; i < 10; i++) begin
            chk("t2_ovld",  out_valid,  1);
            chk("t2_odata", out_data,   16'hEDCB);
            chk("t2_inrdy", in_ready,   0);
            chk("t2_avld",  avec_valid, 0);
            tick();
        end
`ifdef V_HIER_PARITY_EN
        chk("t2_opar", out_par, 4'hB);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t2_ovld_fall", out_valid,  0);
        chk("t2_inrdy",     in_ready,   1);
        chk("t2_noaccept",  avec_valid, 0);

        // Back-to-back FFFF then 0000
        in_data  = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_data = 16'h0000;
        repeat (4 + PAR) tick();
        chk("t3_ovld_a",  out_valid, 1);
        chk("t3_odata_a", out_data,  16'h0000);
        cnt = 4 + PAR;
        while (!in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("t3_gap", cnt + 1, 6 + PAR);
        tick();
        in_valid = 1'b0;
        chk("t3_acc_b", avec_valid, 1);
        chk("t3_avec_b", avec, 4'h0);
        repeat (4 + PAR) tick();
        chk("t3_ovld_b",  out_valid, 1);
        chk("t3_odata_b", out_data,  16'hFFFF);
`ifdef V_HIER_PARITY_EN
        chk("t3_opar_b", out_par, 4'hF);
`endif
        tick();
        chk("t3_ovld_fall", out_valid, 0);

        // Mid-word reset during cycle 2 of the burst
        in_data  = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_avec_pre", avec, 4'h3);
        reset = 1'b1;
        #1;
        chk("t4_in_ready",   in_ready,   1);
        chk("t4_avec",       avec,       0);
        chk("t4_avec_valid", avec_valid, 0);
        chk("t4_avec_last",  avec_last,  0);
        chk("t4_out_data",   out_data,   0);
        chk("t4_out_par",    out_par,    0);
        chk("t4_out_valid",  out_valid,  0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("t4_no_ovld", seen, 0);
        in_data  = 16'h5A5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4_avec_new", avec, 4'hA);
        repeat (4 + PAR) tick();
        chk("t4_ovld_new",  out_valid, 1);
        chk("t4_odata_new", out_data,  16'hA5A5);
        tick();

        // Width sweep NIBS=2
        b_in_data   = 8'h5A;
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk("t5_avec0", b_avec,      4'hA);
        chk("t5_last0", b_avec_last, 0);
        tick();
        chk("t5_avec1", b_avec,      4'h5);
        chk("t5_last1", b_avec_last, 32'(1 - PAR));
        tick();
`ifdef V_HIER_PARITY_EN
        chk("t5_avecp", b_avec,      4'hF);
        chk("t5_lastp", b_avec_last, 1);
        tick();
`endif
        chk("t5_ovld",  b_out_valid, 1);
        chk("t5_odata", b_out_data,  8'hA5);
`ifdef V_HIER_PARITY_EN
        chk("t5_opar",  b_out_par,   4'h0);
`endif
        tick();
        chk("t5_inrdy", b_in_ready,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
